serial_byte_loader: RTL and testbench
=====================================

SERIAL_BYTE_LOADER -- requirements
Module: serial_byte_loader

Interface
REQ-001 SHALL have parameter: MSB_FIRST, 1, 1 = first accepted bit lands in data bit 7; 0 = first accepted bit lands in data bit 0.
REQ-002 SHALL have port: clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: bit_in  input  1  serial data bit.
REQ-005 SHALL have port: bit_valid  input  1  bit_in is offered this cycle.
REQ-006 SHALL have port: clear  input  1  synchronous abort of the partially assembled byte.
REQ-007 SHALL have port: commit  input  1  request to write the assembled byte downstream.
REQ-008 SHALL have port: data_out  output  8  byte presented to the downstream byte store's data input.
REQ-009 SHALL have port: store  output  1  one-cycle write enable to the downstream byte store.
REQ-010 SHALL have port: bit_count  output  4  number of bits held, 0..8.
REQ-011 SHALL have port: full  output  1  high when bit_count == 8.
REQ-012 SHALL have port: overflow  output  1  sticky flag: a bit was offered while full.

Function
REQ-013 SHALL implement a state machine with states SHIFT, FULL and STORE.
REQ-014 SHALL, in SHIFT with bit_valid=1, accept bit_in into the internal shift register and increment bit_count by 1.
REQ-015 SHALL place bits as follows: MSB_FIRST=1 shifts left with the new bit at bit 0; MSB_FIRST=0 shifts right with the new bit at bit 7.
REQ-016 SHALL transition SHIFT -> FULL on the edge that accepts the 8th bit; full=1 and bit_count=8 in the next cycle.
REQ-017 SHALL, in FULL, ignore bit_valid for data purposes and set overflow=1 when bit_valid=1; overflow stays set until reset.
REQ-018 SHALL, in FULL with commit=1, load data_out with the assembled byte and transition to STORE.
REQ-019 SHALL drive store=1 for exactly the one cycle spent in STORE; store=0 in all other states.
REQ-020 SHALL, on leaving STORE, return to SHIFT with bit_count=0 and the shift register cleared; a bit_valid during the STORE cycle is ignored and does not set overflow.
REQ-021 SHALL change data_out only on entry to STORE, so data_out is stable during and after the store pulse (hold for the downstream latch).
REQ-022 SHALL ignore commit in SHIFT: no partial-byte write and no flag.
REQ-023 SHALL, in SHIFT with bit_valid=1 and commit=1 on the 8th bit, accept the bit only; commit is not remembered.
REQ-024 SHALL, when clear=1 in SHIFT or FULL, go to SHIFT with bit_count=0 and the shift register cleared; data_out and overflow are unchanged; clear overrides bit_valid and commit.
REQ-025 SHALL, when clear=1 during STORE, still complete the store pulse; clear has no additional effect.
REQ-026 SHALL keep bit_count saturated at 8 in FULL; it never wraps.

Reset
REQ-027 SHALL, with reset=1 at a rising edge, set state=SHIFT, shift register=0, bit_count=0, data_out=8'h00, store=0, full=0 and overflow=0.
REQ-028 SHALL give reset priority over all other inputs, including mid-byte and during STORE; a store pulse in progress ends the next cycle with store=0.

Verification
REQ-029 SHALL cover: MSB_FIRST=1, bits 1,0,1,0,0,1,0,1, then commit -> full=1 after the 8th bit, store=1 for one cycle, data_out=8'hA5.
REQ-030 SHALL cover: MSB_FIRST=0 with the same bit sequence, then commit -> data_out=8'hA5 bit-reversed, i.e. 8'hA5.
REQ-031 SHALL cover: MSB_FIRST=1, 3 bits, clear, then 8 bits of 1, then commit -> data_out=8'hFF, bit_count shows 3 then 0 then 8.
REQ-032 SHALL cover: commit after 5 bits -> store stays 0; bit_valid while full -> overflow=1, which persists after a later commit.
REQ-033 SHALL cover: a first byte of 8'h3C committed, then 4 bits of a second byte -> data_out stays 8'h3C throughout.
REQ-034 SHALL cover: reset asserted in the STORE cycle -> next cycle store=0, data_out=8'h00, bit_count=0, overflow=0.

Source files
------------

// File: rtl/serial_byte_loader.sv
// Serial-to-parallel byte loader: assembles eight serial bits, then writes the
// byte downstream with a one-cycle store pulse while holding data_out stable.
module serial_byte_loader #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       clear,
  input  logic       commit,
  output logic [7:0] data_out,
  output logic       store,
  output logic [3:0] bit_count,
  output logic       full,
  output logic       overflow
);

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    FULL  = 2'd1,
    STORE = 2'd2
  } state_t;

  state_t     r_state,   w_state_nx;
  logic [7:0] r_shift,   w_shift_nx;
  logic [7:0] r_data,    w_data_nx;
  logic [3:0] r_count,   w_count_nx;
  logic       r_ovf,     w_ovf_nx;
  logic [7:0] w_shifted;

  // Bit order is fixed at elaboration; only one of the two shifts is built.
  assign w_shifted = MSB_FIRST ? {r_shift[6:0], bit_in} : {bit_in, r_shift[7:1]};

  // NOTE: every next-value gets its hold value first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_data_nx  = r_data;
    w_count_nx = r_count;
    w_ovf_nx   = r_ovf;

    unique case (r_state)
      SHIFT: begin
        if (clear) begin
          w_shift_nx = '0;
          w_count_nx = '0;
        end else if (bit_valid) begin
          w_shift_nx = w_shifted;
          w_count_nx = r_count + 4'd1;
          if (r_count == 4'd7) w_state_nx = FULL;
        end
      end
      FULL: begin
        if (clear) begin
          w_state_nx = SHIFT;
          w_shift_nx = '0;
          w_count_nx = '0;
        end else begin
          if (bit_valid) w_ovf_nx = 1'b1;
          // data_out is only ever loaded here, so it holds through and after the pulse.
          if (commit) begin
            w_data_nx  = r_shift;
            w_state_nx = STORE;
          end
        end
      end
      STORE: begin
        w_state_nx = SHIFT;
        w_shift_nx = '0;
        w_count_nx = '0;
      end
      default: begin
        w_state_nx = SHIFT;
        w_shift_nx = '0;
        w_count_nx = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SHIFT;
      r_shift <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_shift <= w_shift_nx;
      r_data  <= w_data_nx;
      r_count <= w_count_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

  assign data_out  = r_data;
  assign store     = (r_state == STORE);
  assign bit_count = r_count;
  assign full      = (r_count == 4'd8);
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_byte_loader.sv
// Scoreboard bench for serial_byte_loader: one MSB-first and one LSB-first
// instance share stimulus; a bit-queue model predicts bytes and status.
module tb_serial_byte_loader;

  logic       clk = 1'b0;
  logic       reset, bit_in, bit_valid, clear, commit;
  logic [7:0] data_out1, data_out0;
  logic       store1, store0, full1, full0, overflow1, overflow0;
  logic [3:0] bit_count1, bit_count0;

  always #5 clk = ~clk;

  serial_byte_loader #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .commit(commit), .data_out(data_out1), .store(store1),
    .bit_count(bit_count1), .full(full1), .overflow(overflow1)
  );

  serial_byte_loader #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .commit(commit), .data_out(data_out0), .store(store0),
    .bit_count(bit_count0), .full(full0), .overflow(overflow0)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  // Reference model: the accepted bits in arrival order plus the sticky flags.
  bit         m_bits[$];
  bit         m_store;
  bit         m_ovf;
  logic [7:0] m_d1, m_d0;
  logic [7:0] exp_q1[$], exp_q0[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack(input bit msb);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < m_bits.size(); i++) begin
      if (msb) v[7-i] = m_bits[i];
      else     v[i]   = m_bits[i];
    end
    return v;
  endfunction

  task automatic model_step(input logic rst, input logic v, input logic b,
                            input logic cm, input logic cl);
    if (rst) begin
      m_bits.delete();
      m_store = 1'b0;
      m_ovf   = 1'b0;
      m_d1    = 8'h00;
      m_d0    = 8'h00;
    end else if (m_store) begin
      m_store = 1'b0;
      m_bits.delete();
    end else if (cl) begin
      m_bits.delete();
    end else if (m_bits.size() == 8) begin
      if (v) m_ovf = 1'b1;
      if (cm) begin
        m_d1 = pack(1'b1);
        m_d0 = pack(1'b0);
        m_store = 1'b1;
        exp_q1.push_back(m_d1);
        exp_q0.push_back(m_d0);
      end
    end else if (v) begin
      m_bits.push_back(b);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic cm,
                       input logic cl, input logic rst);
    bit_valid = v;
    bit_in    = b;
    commit    = cm;
    clear     = cl;
    reset     = rst;
    @(posedge clk);
    model_step(rst, v, b, cm, cl);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, v[7-i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_commit();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: status compared every cycle, stored bytes popped from the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("store_msb",     store1,     m_store);
      check("store_lsb",     store0,     m_store);
      check("count_msb",     bit_count1, m_bits.size());
      check("count_lsb",     bit_count0, m_bits.size());
      check("full_msb",      full1,      m_bits.size() == 8);
      check("full_lsb",      full0,      m_bits.size() == 8);
      check("overflow_msb",  overflow1,  m_ovf);
      check("overflow_lsb",  overflow0,  m_ovf);
      check("hold_data_msb", data_out1,  m_d1);
      check("hold_data_lsb", data_out0,  m_d0);
      if (store1) begin
        if (exp_q1.size() == 0) check("unexpected_store_msb", 1, 0);
        else check("stored_byte_msb", data_out1, exp_q1.pop_front());
      end
      if (store0) begin
        if (exp_q0.size() == 0) check("unexpected_store_lsb", 1, 0);
        else check("stored_byte_lsb", data_out0, exp_q0.pop_front());
      end
    end
  end

  initial begin
    bit_valid = 1'b0; bit_in = 1'b0; commit = 1'b0; clear = 1'b0; reset = 1'b1;
    do_reset();
    mon_en = 1'b1;
    idle(1);

    // A5 in both bit orders, with a pulse held afterwards.
    send_bits(8'hA5, 8);
    do_commit();
    idle(3);

    // Partial byte, clear, then a byte of ones.
    send_bits(8'hE0, 3);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_bits(8'hFF, 8);
    do_commit();
    idle(2);

    // Commit on a partial byte is ignored; bits while full set sticky overflow.
    send_bits(8'h5A, 5);
    do_commit();
    send_bits(8'h40, 3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_commit();
    idle(2);

    // Commit together with the 8th bit is not remembered.
    do_reset();
    send_bits(8'h96, 7);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Clear in FULL overrides commit and bit_valid.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);

    // 3C committed, bit offered and clear during STORE, then a partial second byte.
    send_bits(8'h3C, 8);
    do_commit();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_bits(8'hC0, 4);
    idle(2);

    // Reset landing in the STORE cycle.
    send_bits(8'h71, 8);
    do_commit();
    do_reset();
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 65, 1'($urandom), $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 3, $urandom_range(0, 299) == 0);
    end
    idle(2);

    @(negedge clk);
    #1;
    check("scoreboard_drained_msb", exp_q1.size(), 0);
    check("scoreboard_drained_lsb", exp_q0.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
